// File: rtl/sl_rx_arbiter_pkg.sv
// Shared definitions for the serial-line receive arbiter: status/config bit positions and FSM states.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package sl_rx_arbiter_pkg;

    // status_w bit indices as produced by the receiver channels
    localparam int STS_LEN_ERR  = 0;
    localparam int STS_WORD_RDY = 3;
    localparam int STS_PAR_ERR  = 4;
    localparam int STS_LVL_ERR  = 5;

    // config word field positions: {9'b0, len[5:0], pce}
    localparam int CFG_PCE     = 0;
    localparam int CFG_LEN_LSB = 1;
    localparam int CFG_LEN_MSB = 6;

    // legal word length window (even values only)
    localparam int MIN_LEN = 8;
    localparam int MAX_LEN = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_CAPTURE,
        ST_PICK,
        ST_OFFER
    } state_t;

    // a word length is usable when it is even and inside the window
    function automatic logic lenValid(input logic [5:0] len);
        return (len[0] == 1'b0) && (len >= 6'(MIN_LEN)) && (len <= 6'(MAX_LEN));
    endfunction

    function automatic logic [15:0] packConfig(input logic [5:0] len, input logic pce);
        logic [15:0] w;
        w = '0;
        w[CFG_LEN_MSB:CFG_LEN_LSB] = len;
        w[CFG_PCE] = pce;
        return w;
    endfunction

endpackage

// File: rtl/sl_rx_arbiter_if.sv
// Host-side bundle of the receive arbiter: config request/ack and the captured-word valid/ready port.
// Latency: n/a (wiring only).
// Backpressure: out_ready throttles out_valid; cfg_req is held by the host until cfg_ack.
interface sl_rx_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) ();
    logic            cfg_req;
    logic            cfg_bcast;
    logic [CH_W-1:0] cfg_ch;
    logic [5:0]      cfg_len;
    logic            cfg_pce;
    logic            cfg_ack;
    logic            cfg_err;

    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_data;
    logic [15:0]     out_status;
    logic [CH_W-1:0] out_ch;
    logic            out_overrun;

    // host side
    modport master (
        output cfg_req, cfg_bcast, cfg_ch, cfg_len, cfg_pce, out_ready,
        input  cfg_ack, cfg_err, out_valid, out_data, out_status, out_ch, out_overrun
    );

    // arbiter side
    modport slave (
        input  cfg_req, cfg_bcast, cfg_ch, cfg_len, cfg_pce, out_ready,
        output cfg_ack, cfg_err, out_valid, out_data, out_status, out_ch, out_overrun
    );
endinterface

// File: rtl/sl_rr_arbiter.sv
// Round-robin pick: first set bit of pending scanning upward from lastGrant+1 with wrap-around.
// Latency: combinational.
// Backpressure: none; the caller decides when to consume the grant.
module sl_rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] pending,
    input  logic [CH_W-1:0]   lastGrant,
    output logic [CH_W-1:0]   grant,
    output logic              anyPending
);

    logic              found;
    logic [CH_W-1:0]   idx;

    // scan NUM_CH slots after lastGrant; the last slot is lastGrant itself
    always_comb begin
        grant      = '0;
        found      = 1'b0;
        idx        = '0;
        anyPending = |pending;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = CH_W'((int'(lastGrant) + k) % NUM_CH);
            if (!found && pending[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sl_rx_arbiter.sv
// Shares one host word port between NUM_CH receivers and sequences per-channel/broadcast config writes.
// Latency: changed pulse at n -> word_picked/out_valid at n+3; 4 cycles minimum per word.
// Backpressure: out_valid holds with stable data until out_ready; new events only set pending/overrun.
module sl_rx_arbiter
    import sl_rx_arbiter_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    ch_changed_i,
    input  logic [16*NUM_CH-1:0] ch_status_i,
    input  logic [32*NUM_CH-1:0] ch_data_i,
    output logic [NUM_CH-1:0]    ch_word_picked_o,
    output logic [NUM_CH-1:0]    ch_wr_enable_o,
    output logic [15:0]          ch_wr_config_o,
    sl_rx_arbiter_if.slave       host
);

    state_t            state, nextState;
    logic [NUM_CH-1:0] pending, overrun;
    logic [NUM_CH-1:0] evSet, capClr;
    logic [CH_W-1:0]   lastGrant, grantReg, arbGrant;
    logic              arbAny;
    logic              cfgOk;

    logic              outValid;
    logic [31:0]       outData;
    logic [15:0]       outStatus;
    logic [CH_W-1:0]   outCh;
    logic              outOverrun;

    sl_rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_rr (
        .pending    (pending),
        .lastGrant  (lastGrant),
        .grant      (arbGrant),
        .anyPending (arbAny)
    );

    // a zero status marks the receiver's own post-pick clear, not a new word
    always_comb begin
        evSet  = '0;
        capClr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            evSet[i]  = ch_changed_i[i] && (ch_status_i[16*i +: 16] != 16'h0);
            capClr[i] = (state == ST_CAPTURE) && (grantReg == CH_W'(i));
        end
    end

    // event latch: a new event beats a same-cycle capture clear; overrun only for an unserviced repeat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            overrun <= '0;
        end else begin
            pending <= evSet | (pending & ~capClr);
            overrun <= ~capClr & (overrun | (evSet & pending));
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // grant bookkeeping, word capture and the output valid flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grantReg   <= '0;
            lastGrant  <= CH_W'(NUM_CH - 1);
            outValid   <= 1'b0;
            outData    <= '0;
            outStatus  <= '0;
            outCh      <= '0;
            outOverrun <= 1'b0;
        end else begin
            if (state == ST_IDLE && !host.cfg_req && arbAny) begin
                grantReg <= arbGrant;
            end
            if (state == ST_CAPTURE) begin
                outData    <= ch_data_i[32*grantReg +: 32];
                outStatus  <= ch_status_i[16*grantReg +: 16];
                outCh      <= grantReg;
                outOverrun <= overrun[grantReg];
                lastGrant  <= grantReg;
                // raised here so it is visible in the PICK cycle together with word_picked
                outValid   <= 1'b1;
            end else if (outValid && host.out_ready) begin
                outValid <= 1'b0;
            end
        end
    end

    // broadcast skips the channel-range check but never the length check
    assign cfgOk = lenValid(host.cfg_len) &&
                   (host.cfg_bcast || ({1'b0, host.cfg_ch} < (CH_W+1)'(NUM_CH)));

    // next state plus the one-cycle strobes; config beats grants in IDLE
    always_comb begin
        nextState        = state;
        ch_word_picked_o = '0;
        ch_wr_enable_o   = '0;
        ch_wr_config_o   = '0;
        host.cfg_ack     = 1'b0;
        host.cfg_err     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (host.cfg_req) begin
                    nextState = ST_CFG;
                end else if (arbAny) begin
                    nextState = ST_CAPTURE;
                end
            end
            ST_CFG: begin
                host.cfg_ack = 1'b1;
                if (cfgOk) begin
                    ch_wr_config_o = packConfig(host.cfg_len, host.cfg_pce);
                    ch_wr_enable_o = host.cfg_bcast ? {NUM_CH{1'b1}} : (NUM_CH'(1) << host.cfg_ch);
                end else begin
                    host.cfg_err = 1'b1;
                end
                nextState = ST_IDLE;
            end
            ST_CAPTURE: begin
                nextState = ST_PICK;
            end
            ST_PICK: begin
                ch_word_picked_o = NUM_CH'(1) << grantReg;
                nextState = ST_OFFER;
            end
            ST_OFFER: begin
                // valid already low means the handshake happened during PICK
                if (!outValid || host.out_ready) begin
                    nextState = ST_IDLE;
                end
            end
            default: nextState = ST_IDLE;
        endcase
    end

    assign host.out_valid   = outValid;
    assign host.out_data    = outData;
    assign host.out_status  = outStatus;
    assign host.out_ch      = outCh;
    assign host.out_overrun = outOverrun;

endmodule

// File: doc/sl_rx_arbiter.md
Name: sl_rx_arbiter

Overview:
- Shares one host-side word output between NUM_CH serial-line receiver channels.
- Latches each channel's data_status_changed event and round-robin grants pending channels.
- Captures the granted channel's data_w/status_w, pulses that channel's word_picked and offers the word on a valid/ready port.
- Also sequences configuration writes (word length, PCE) into one channel or all channels.

Parameters:
- NUM_CH, 4, number of receiver channels (2..8).
- CH_W, 2, channel index width, $clog2(NUM_CH).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- ch_changed_i  in  NUM_CH  per-channel data_status_changed pulses.
- ch_status_i  in  16*NUM_CH  per-channel status_w, channel i at [16i+15:16i].
- ch_data_i  in  32*NUM_CH  per-channel data_w.
- ch_word_picked_o  out  NUM_CH  one-cycle word_picked pulse to the granted channel.
- ch_wr_enable_o  out  NUM_CH  one-cycle config write strobe per channel.
- ch_wr_config_o  out  16  config word shared by all channels: {9'b0, len[5:0], pce}.
- cfg_req_i  in  1  host config request, held until cfg_ack_o.
- cfg_bcast_i  in  1  1 = write all channels; 0 = write cfg_ch_i.
- cfg_ch_i  in  CH_W  target channel.
- cfg_len_i  in  6  word length.
- cfg_pce_i  in  1  parity-check enable.
- cfg_ack_o  out  1  one-cycle acknowledge.
- cfg_err_o  out  1  valid with cfg_ack_o: request rejected.
- out_valid_o  out  1  word available.
- out_ready_i  in  1  host accepts.
- out_data_o  out  32  captured data_w.
- out_status_o  out  16  captured status_w.
- out_ch_o  out  CH_W  source channel.
- out_overrun_o  out  1  an event from this channel was overwritten before service.

Behaviour:
- Reset:
  - All outputs, pending[], overrun[] and out registers are 0.
  - last_grant = NUM_CH-1, so channel 0 has first priority.
  - State = IDLE.
- Event latch, every cycle per channel i:
  - A changed pulse with status != 0 sets pending[i]. Changed with status == 0, the post-pick clear, is ignored.
  - If pending[i] is already 1 and not being captured this cycle, overrun[i] is also set.
  - Set wins over a same-cycle capture clear.
- FSM states: IDLE, CFG, CAPTURE, PICK, OFFER.
- IDLE:
  - If cfg_req_i, go to CFG. Config has priority over grants.
  - Else, if any pending, grant the first pending channel scanning from last_grant+1 with wrap-around, record the grant, and go to CAPTURE.
- CFG, one cycle:
  - The request is valid when cfg_len_i is even, 8..32, and cfg_ch_i < NUM_CH, or cfg_bcast_i is set.
  - Valid: drive ch_wr_config_o and assert ch_wr_enable_o on the target channel (all bits if broadcast), cfg_ack_o = 1, cfg_err_o = 0.
  - Invalid: no strobe, cfg_ack_o = 1, cfg_err_o = 1.
  - Go to IDLE. The host drops cfg_req_i after the ack; a held request is serviced again.
- CAPTURE:
  - Load out_data/out_status/out_ch from the granted channel.
  - Load out_overrun from overrun[g], then clear pending[g] and overrun[g].
  - last_grant = g. Go to PICK.
- PICK:
  - ch_word_picked_o[g] = 1 for exactly one cycle.
  - out_valid_o rises in the same cycle. Go to OFFER.
- OFFER:
  - Hold out_* stable while out_valid_o = 1 and out_ready_i = 0.
  - On handshake, drop out_valid_o next cycle and go to IDLE.
  - out_ready_i asserted in the PICK cycle also counts as a handshake.
- Latency:
  - changed pulse at cycle n → pending at n+1 → CAPTURE at n+2 → word_picked and out_valid_o at n+3, if in IDLE with no cfg_req.
  - Minimum cycles per word: 4 (IDLE, CAPTURE, PICK, OFFER with ready high).
- New events during CAPTURE/PICK/OFFER only set pending/overrun; captured output is never modified.
- Reset mid-operation aborts immediately: strobes and pulses go low and pending events are lost.

Decomposition:
- sl_pkg:
  - status bit indices: LEN_ERR = 0, WORD_RDY = 3, PAR_ERR = 4, LVL_ERR = 5.
  - config field positions: PCE = 0, LEN = 6:1.
  - MIN_LEN = 8, MAX_LEN = 32.
  - FSM state enum.
- Sub-module sl_rr_arbiter: combinational round-robin pick from pending[] and last_grant, outputting grant index and any_pending.

Test Plan:
- Pulse ch 2 changed with status 16'h0008, data 32'hA5A5_0F0F, out_ready = 1:
  - word_picked[2] pulses 3 cycles later.
  - out_data = A5A50F0F, out_status = 0008, out_ch = 2, out_overrun = 0.
- Same-cycle changed on ch 0, 1, 3 (status 0008), out_ready = 1:
  - words emerge in order 0, 1, 3.
  - A further ch 0 event then a ch 1 event emerge in order 0, 1.
- Hold out_ready = 0 for 20 cycles:
  - out_* remain stable and out_valid stays 1.
  - A second ch 1 changed (status 0008) arrives twice during OFFER: the next ch 1 word has out_overrun = 1.
- cfg_bcast = 1, len = 16, pce = 1:
  - all ch_wr_enable bits high for 1 cycle with ch_wr_config = 16'h0021, cfg_ack = 1, cfg_err = 0.
  - Then len = 9: cfg_ack = 1, cfg_err = 1, no strobes.
- cfg_req and a ch 0 event arrive together: CFG strobe occurs first, word output follows 3 cycles later. Then a changed pulse with status 0000: no output.
- Assert rst during OFFER:
  - out_valid, pending and all strobes read 0 asynchronously.
  - After release, channel 0 has first priority.
